// File: rtl/tile_row_sequencer.sv
// tile_row_sequencer: walks one tile-map row per scanline, fetches each tile's pixel row and hands it to the quadrupler.
// Define TILE_SKIP_EMPTY_EN to skip index-0 tiles without emitting a word.
module tile_row_sequencer #(
  parameter int NUM_COLS = 41,
  parameter int COL_W = 6
) (
  input  logic        clk_draw,
  input  logic        rst_draw,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic [9:0]  scroll_x,
  output logic        map_rd,
  output logic [11:0] map_addr,
  input  logic [7:0]  map_data,
  output logic        tile_rd,
  output logic [9:0]  tile_addr,
  input  logic [31:0] tile_data,
  output logic [31:0] tile_pixels,
  output logic [3:0]  tile_valid_mask,
  output logic [10:0] tile_x,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        busy,
  output logic        line_done
);
  typedef enum logic [2:0] {IDLE, MAP, TILE, LOAD, EMIT} state_t;
  state_t state;
  logic [COL_W-1:0] col, col_nxt;
  logic [9:0] y, sx;
  logic [7:0] idx;
  logic last, skip, adv, unused;
  assign last = col == COL_W'(NUM_COLS - 1);
  assign col_nxt = col + 1'b1;
`ifdef TILE_SKIP_EMPTY_EN
  assign skip = state == TILE && map_data == 8'd0;
`else
  assign skip = 1'b0;
`endif
  assign adv = skip || (state == EMIT && px_ready);
  // map_data is only valid in TILE, so the pixel fetch is issued combinationally from it
  assign tile_rd = state == TILE && !skip;
  assign tile_addr = tile_rd ? {map_data, y[3:2]} : 10'd0;
  assign unused = ^y[1:0];
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state <= IDLE;
      col <= '0;
      y <= '0;
      sx <= '0;
      idx <= '0;
      map_rd <= 1'b0;
      map_addr <= '0;
      tile_pixels <= '0;
      tile_valid_mask <= '0;
      tile_x <= '0;
      px_valid <= 1'b0;
      busy <= 1'b0;
      line_done <= 1'b0;
    end else begin
      map_rd <= 1'b0;
      line_done <= 1'b0;
      case (state)
        IDLE: if (line_start) begin
          y <= line_y;
          sx <= scroll_x;
          col <= '0;
          busy <= 1'b1;
          map_rd <= 1'b1;
          map_addr <= {line_y[9:4], scroll_x[9:4]};
          state <= MAP;
        end
        MAP: state <= TILE;
        TILE: begin
          idx <= map_data;
          state <= LOAD;
        end
        LOAD: begin
          tile_pixels <= tile_data;
          tile_valid_mask <= idx == 8'd0 ? 4'd0 :
            {|tile_data[31:24], |tile_data[23:16], |tile_data[15:8], |tile_data[7:0]};
          // x 0..15 of the line buffer is a hidden guard absorbing the fine scroll
          tile_x <= 11'({col, 4'b0000}) + 11'd16 - 11'(sx[3:0]);
          px_valid <= 1'b1;
          state <= EMIT;
        end
        EMIT: ;
        default: state <= IDLE;
      endcase
      if (adv) begin
        px_valid <= 1'b0;
        if (last) begin
          line_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          col <= col_nxt;
          map_rd <= 1'b1;
          map_addr <= {y[9:4], sx[9:4] + 6'(col_nxt)};
          state <= MAP;
        end
      end
    end
  end
endmodule

// File: tb/tb_tile_row_sequencer.sv
// tb_tile_row_sequencer: RAM models plus a per-line reference model feeding a scoreboard; a monitor pops on each handshake.
`timescale 1ns/1ps
module tb_tile_row_sequencer;
  localparam int NC = 41;
  logic clk_draw = 1'b0, rst_draw = 1'b1, line_start = 1'b0, px_ready = 1'b0;
  logic [9:0] line_y = '0, scroll_x = '0;
  logic map_rd, tile_rd, px_valid, busy, line_done;
  logic [11:0] map_addr;
  logic [7:0] map_data = '0;
  logic [9:0] tile_addr;
  logic [31:0] tile_data = '0;
  logic [31:0] tile_pixels;
  logic [3:0] tile_valid_mask;
  logic [10:0] tile_x;
  typedef struct packed {logic [31:0] pix; logic [3:0] mask; logic [10:0] x;} word_t;
  word_t sb[$];
  word_t held, e;
  logic [7:0] map_mem [4096];
  logic [31:0] tile_mem [1024];
  logic [11:0] map_log[$];
  logic [9:0] tile_log[$];
  int errors = 0, checks = 0, done_cnt = 0, words = 0, cyc = 0, first_map = 0, done_cyc = 0;
  int rdy_mode = 0, exp_words = 0;
  bit held_v = 0, prev_map = 0, prev_tile = 0;

  tile_row_sequencer dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw), .line_start(line_start), .line_y(line_y),
    .scroll_x(scroll_x), .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data),
    .tile_rd(tile_rd), .tile_addr(tile_addr), .tile_data(tile_data),
    .tile_pixels(tile_pixels), .tile_valid_mask(tile_valid_mask), .tile_x(tile_x),
    .px_valid(px_valid), .px_ready(px_ready), .busy(busy), .line_done(line_done)
  );

  initial forever #5 clk_draw = ~clk_draw;
  always @(posedge clk_draw) cyc <= cyc + 1;

  // RAMs return garbage unless read the cycle before
  always @(posedge clk_draw) begin
    map_data <= map_rd ? map_mem[map_addr] : 8'($urandom);
    tile_data <= tile_rd ? tile_mem[tile_addr] : 32'($urandom);
  end

  initial forever begin
    @(posedge clk_draw);
    #1;
    px_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk_draw);
    if (rst_draw) begin
      held_v = 0;
      prev_map = 0;
      prev_tile = 0;
    end else begin
      if (map_rd) begin
        chk("map_rd_single", 64'({prev_map, tile_rd}), 64'd0);
        if (map_log.size() == 0) first_map = cyc;
        map_log.push_back(map_addr);
      end
      if (tile_rd) begin
        chk("tile_rd_single", 64'(prev_tile), 64'd0);
        tile_log.push_back(tile_addr);
      end
      if (held_v) chk("stall_hold", 64'({px_valid, tile_pixels, tile_valid_mask, tile_x}), 64'({1'b1, held}));
      held_v = px_valid && !px_ready;
      held = '{pix: tile_pixels, mask: tile_valid_mask, x: tile_x};
      if (px_valid && px_ready) begin
        words++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got x=%0d with empty scoreboard", tile_x);
        end else begin
          e = sb.pop_front();
          chk("pixels", 64'(tile_pixels), 64'(e.pix));
          chk("mask", 64'(tile_valid_mask), 64'(e.mask));
          chk("tile_x", 64'(tile_x), 64'(e.x));
        end
      end
      if (line_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("words_left_at_done", 64'(sb.size()), 64'd0);
      end
      prev_map = map_rd;
      prev_tile = tile_rd;
    end
  end

  task automatic expect_line(input logic [9:0] ly, input logic [9:0] sx);
    for (int c = 0; c < NC; c++) begin
      int mc, x;
      logic [7:0] idx;
      logic [31:0] d;
      logic [3:0] m;
      mc = (int'(sx) / 16 + c) % 64;
      idx = map_mem[(int'(ly) / 16) * 64 + mc];
      d = tile_mem[int'(idx) * 4 + (int'(ly) / 4) % 4];
`ifdef TILE_SKIP_EMPTY_EN
      if (idx == 8'd0) continue;
`endif
      for (int i = 0; i < 4; i++) m[3 - i] = idx != 8'd0 && d[31 - 8 * i -: 8] != 8'd0;
      x = c * 16 + 16 - int'(sx) % 16;
      sb.push_back('{pix: d, mask: m, x: 11'(x)});
    end
    exp_words = sb.size();
    map_log.delete();
    tile_log.delete();
    words = 0;
  endtask

  task automatic start_line(input logic [9:0] ly, input logic [9:0] sx);
    @(negedge clk_draw);
    line_y = ly;
    scroll_x = sx;
    line_start = 1'b1;
    @(negedge clk_draw);
    line_start = 1'b0;
    line_y = 10'($urandom);
    scroll_x = 10'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_draw);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL line_done_timeout: none after %0d cycles", budget);
    end
  endtask

  task automatic run_line(input logic [9:0] ly, input logic [9:0] sx, input int budget);
    int d0;
    d0 = done_cnt;
    expect_line(ly, sx);
    start_line(ly, sx);
    wait_done(d0, budget);
    chk("word_count", 64'(words), 64'(exp_words));
    @(negedge clk_draw);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int d0, n;
    logic [9:0] ly, sx;
    for (int i = 0; i < 4096; i++) map_mem[i] = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
    for (int i = 0; i < 1024; i++) tile_mem[i] = $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom) & 32'hFF00FF00;
    repeat (3) @(negedge clk_draw);
    chk("reset_ctrl", 64'({map_rd, tile_rd, px_valid, busy, line_done}), 64'd0);
    chk("reset_addr", 64'({map_addr, tile_addr}), 64'd0);
    chk("reset_data", 64'({tile_pixels, tile_valid_mask, tile_x}), 64'd0);
    rst_draw = 1'b0;

    // Directed line with a line_start landing on the final handshake
    for (int c = 0; c < 64; c++) map_mem[2 * 64 + c] = 8'd3;
    tile_mem[13] = 32'h01020304;
    rdy_mode = 0;
    d0 = done_cnt;
    expect_line(10'd37, 10'd0);
    start_line(10'd37, 10'd0);
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk_draw);
      n++;
      line_start = map_log.size() == NC && px_valid;
    end
    line_start = 1'b0;
    wait_done(d0, 10);
    chk("first_map_addr", 64'(map_log[0]), 64'h080);
    chk("first_tile_addr", 64'(tile_log[0]), 64'h00D);
    chk("latency_map_to_done", 64'(done_cyc - first_map), 64'd164);
    chk("words_directed", 64'(words), 64'd41);
    repeat (3) @(negedge clk_draw);
    chk("no_restart", 64'({busy, 6'(map_log.size())}), 64'(NC));

    // Coarse-scroll wrap
    run_line(10'd100, 10'h3F5, 500);
    chk("wrap_col0", 64'(map_log[0][5:0]), 64'd63);
    chk("wrap_col1", 64'(map_log[1][5:0]), 64'd0);

    // Transparent bytes and index-0 masking
    map_mem[12 * 64] = 8'd7;
    map_mem[12 * 64 + 1] = 8'd0;
    tile_mem[7 * 4 + 2] = 32'h00050006;
    tile_mem[2] = 32'hFFFFFFFF;
    run_line(10'd200, 10'd0, 500);

    // Stall in EMIT with ignored line_start pulses
    rdy_mode = 2;
    d0 = done_cnt;
    ly = 10'($urandom);
    sx = 10'($urandom);
    expect_line(ly, sx);
    start_line(ly, sx);
    n = 0;
    while (!px_valid && n < 20) begin
      @(negedge clk_draw);
      n++;
    end
    chk("stall_px_valid", 64'(px_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      line_start = k % 3 == 0;
      @(negedge clk_draw);
      chk("stall_no_reads", 64'({map_rd, tile_rd}), 64'd0);
    end
    line_start = 1'b0;
    rdy_mode = 0;
    wait_done(d0, 500);
    chk("stall_words", 64'(words), 64'(exp_words));
    repeat (3) @(negedge clk_draw);
    chk("stall_idle", 64'({busy, 6'(map_log.size())}), 64'(NC));

    // Alternating empty / index-4 tiles
    for (int c = 0; c < 64; c++) map_mem[4 * 64 + c] = c % 2 ? 8'd4 : 8'd0;
    run_line(10'd64, 10'd0, 500);
`ifdef TILE_SKIP_EMPTY_EN
    chk("skip_tile_reads", 64'(tile_log.size()), 64'd20);
`else
    chk("skip_tile_reads", 64'(tile_log.size()), 64'd41);
`endif

    // Randomized lines with random back-pressure
    rdy_mode = 1;
    for (int l = 0; l < 12; l++) run_line(10'($urandom), 10'($urandom), 3000);

    // Reset while stalled in EMIT of column 5
    rdy_mode = 0;
    ly = 10'($urandom);
    sx = 10'($urandom);
    expect_line(ly, sx);
    start_line(ly, sx);
    n = 0;
    while (map_log.size() < 6 && n < 100) begin
      @(negedge clk_draw);
      n++;
    end
    rdy_mode = 2;
    n = 0;
    while (!px_valid && n < 20) begin
      @(negedge clk_draw);
      n++;
    end
    chk("col5_stalled", 64'({px_valid, 6'(map_log.size())}), 64'({1'b1, 6'd6}));
    rst_draw = 1'b1;
    sb.delete();
    d0 = done_cnt;
    @(negedge clk_draw);
    chk("midreset_ctrl", 64'({map_rd, tile_rd, px_valid, busy, line_done}), 64'd0);
    chk("midreset_data", 64'({tile_pixels, tile_valid_mask, tile_x}), 64'd0);
    chk("midreset_addr", 64'({map_addr, tile_addr}), 64'd0);
    rst_draw = 1'b0;
    rdy_mode = 0;
    repeat (10) @(negedge clk_draw);
    chk("midreset_no_done", 64'(done_cnt), 64'(d0));
    sx = 10'($urandom);
    run_line(10'($urandom), sx, 500);
    chk("restart_col0", 64'(map_log[0][5:0]), 64'(sx[9:4]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_row_sequencer.md
Name: tile_row_sequencer

Overview:
- Per-scanline controller that walks one row of the tile map, fetches each tile's source pixel row and feeds the pixel quadrupler one tile per handshake.
- Produces tile_pixels, tile_valid_mask and tile_x in line-buffer coordinates.
- Sits between tile map/tile pixel RAMs and the quadrupler, in the clk_draw domain.
- Handles horizontal scroll and transparent-pixel masking.

Parameters:
- NUM_COLS, 41, tiles emitted per line (40 visible + 1 partial for fine scroll)
- COL_W, 6, width of column counter; must satisfy 2**COL_W >= NUM_COLS

Ports:
- clk_draw  in  1  draw clock
- rst_draw  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse: begin a new scanline
- line_y  in  10  screen line number, sampled on accepted line_start
- scroll_x  in  10  horizontal scroll in screen pixels, sampled on accepted line_start
- map_rd  out  1  tile map read strobe
- map_addr  out  12  {map_row[5:0], map_col[5:0]}
- map_data  in  8  tile index; valid the cycle after map_rd
- tile_rd  out  1  tile pixel read strobe
- tile_addr  out  10  {tile_index[7:0], src_row[1:0]}
- tile_data  in  32  four 8-bit source pixels; byte 0 = leftmost = bits [31:24]; valid the cycle after tile_rd
- tile_pixels  out  32  pixels to quadrupler
- tile_valid_mask  out  4  bit 3 = leftmost pixel opaque
- tile_x  out  11  line-buffer x of first output pixel
- px_valid  out  1  output word valid
- px_ready  in  1  quadrupler/line buffer accepts word
- busy  out  1  high from accepted line_start until line_done
- line_done  out  1  one-cycle pulse after last tile handshake

Behaviour:
- Reset: state IDLE; every output 0; column counter 0; latched line_y/scroll_x 0. Reset mid-line abandons the line; no line_done.
- States: IDLE, MAP, TILE, LOAD, EMIT.
- IDLE:
  - line_start -> latch line_y, scroll_x; col=0; busy=1; go to MAP.
  - line_start while busy is ignored.
- MAP:
  - map_rd=1 for exactly one cycle.
  - map_row = line_y[9:4]; map_col = (scroll_x[9:4] + col) mod 64, wrapping at 64.
  - Next state: TILE.
- TILE:
  - Capture map_data as tile_index.
  - tile_rd=1 for one cycle; tile_addr = {map_data, line_y[3:2]}.
  - Next state: LOAD.
- LOAD:
  - Register tile_pixels=tile_data.
  - tile_valid_mask[3-i] = (byte i != 0); forced to 0000 when tile_index==0.
  - tile_x = col*16 + 16 - scroll_x[3:0], 11-bit; line-buffer x 0..15 is a hidden left guard.
  - Next state: EMIT.
- EMIT:
  - px_valid=1, outputs stable until px_valid && px_ready.
  - On handshake: px_valid drops next cycle.
  - If col==NUM_COLS-1: line_done=1 for one cycle, busy=0, go to IDLE.
  - Otherwise: col+1, go to MAP.
- Minimum 4 cycles per tile. A handshake in the first EMIT cycle gives map_rd for the next tile on the following cycle.
- px_valid never deasserts without handshake. tile_pixels, tile_valid_mask and tile_x hold their last values outside EMIT.
- map_rd and tile_rd are never asserted together or for more than one cycle.
- line_start coincident with the last EMIT handshake is ignored (busy still 1).

Optional Feature:
- Macro: TILE_SKIP_EMPTY_EN.
- When defined:
  - tile_index==0 in TILE suppresses tile_rd and skips LOAD/EMIT.
  - Advances col (or finishes the line) and returns to MAP next cycle; no word emitted for that column.
  - If the skipped tile is the last column, line_done pulses the cycle after TILE.
- When undefined: index-0 tiles go through all states and are emitted with mask 0000.

Test Plan:
- Reset mid-EMIT (px_ready=0, col=5): all outputs 0 next cycle; busy=0; no line_done; new line_start restarts at col 0.
- line_y=37, scroll_x=0, map row 2 cols 0..40 = index 3, tile RAM [3*4+1]=32'h01020304, px_ready=1:
  - 41 words emitted, each tile_pixels=32'h01020304, mask 1111.
  - tile_x=16,32,...,656.
  - map_addr first = 12'h080, tile_addr = 10'h00D.
  - line_done one cycle after the 41st handshake; 164 cycles from MAP to line_done.
- scroll_x=10'h3F5 (coarse 63, fine 5):
  - First map_addr col field = 63, second = 0 (wrap).
  - tile_x first = 11, second = 27.
- tile_data=32'h00050006, index 7: mask 0101. Index 0 with tile_data=32'hFFFFFFFF: mask 0000 (macro off).
- px_ready held low 10 cycles in EMIT:
  - px_valid and all outputs stable.
  - No map_rd/tile_rd; line_start pulses during that time ignored.
- TILE_SKIP_EMPTY_EN on, cols 0..40 alternate index 0/4:
  - 20 words emitted, tile_x=32,64,...,640.
  - No tile_rd for even cols; line_done still pulses.
